// File: rtl/euler_pkg.sv
// Shared types and fixed-point helpers for the Euler state-update block.
// EULER_SAT_EN selects saturating narrowing instead of two's-complement wrap.
package euler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    COMMIT,
    STEP_END
  } state_t;

  localparam int unsigned FRAC_BITS_DEF = 8;
  localparam logic [15:0] SAT_MAX       = 16'h7FFF;
  localparam logic [15:0] SAT_MIN       = 16'h8000;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } fx_res_t;

  // Fixed-point multiply, rescale by frac, then fit into a width-bit signed word.
  function automatic fx_res_t fx_mul_narrow(input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int unsigned        frac,
                                            input int unsigned        width);
    logic signed [63:0] prod;
    logic signed [63:0] lim_max;
    logic signed [63:0] lim_min;
    fx_res_t            r;
    prod    = (a * b) >>> frac;
    lim_max = (64'sd1 <<< (width - 1)) - 64'sd1;
    lim_min = -(64'sd1 <<< (width - 1));
    r.ovf   = (prod > lim_max) || (prod < lim_min);
    r.val   = prod;
`ifdef EULER_SAT_EN
    if (prod > lim_max) r.val = lim_max;
    else if (prod < lim_min) r.val = lim_min;
`endif
    return r;
  endfunction

endpackage

// File: rtl/euler_fx_mac_update.sv
// Two-stage h*f narrowing multiply and x+p add with sticky overflow.
// EULER_SAT_EN makes both the narrowing and the add saturate.
module euler_fx_mac_update
  import euler_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter int unsigned ROW_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [ROW_W-1:0]     in_row,
  input  logic [DATA_SIZE-1:0] step_h,
  output logic [ROW_W-1:0]     s1_row,
  input  logic [DATA_SIZE-1:0] x_row,
  output logic                 out_valid,
  output logic [ROW_W-1:0]     out_row,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 overflow
);

  localparam int unsigned XW = 64 - DATA_SIZE;

  logic signed [63:0]   a_ext;
  logic signed [63:0]   h_ext;
  fx_res_t              mul;
  logic                 mul_ovf;
  logic                 s1_valid;
  logic [DATA_SIZE-1:0] s1_p;
  logic [DATA_SIZE:0]   sum_full;
  logic                 add_ovf;

  always_comb begin
    a_ext   = {{XW{in_data[DATA_SIZE-1]}}, in_data};
    h_ext   = {{XW{step_h[DATA_SIZE-1]}}, step_h};
    mul     = fx_mul_narrow(a_ext, h_ext, FRAC_BITS, DATA_SIZE);
    // In wrap mode the second term equals mul.ovf; in saturate mode it is zero.
    mul_ovf = mul.ovf | (mul.val[63:DATA_SIZE-1] != {(XW + 1){mul.val[DATA_SIZE-1]}});
  end

  always_ff @(posedge clk) begin
    if (rst || clr) s1_valid <= 1'b0;
    else            s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    s1_p   <= mul.val[DATA_SIZE-1:0];
    s1_row <= in_row;
  end

  always_comb begin
    sum_full  = {x_row[DATA_SIZE-1], x_row} + {s1_p[DATA_SIZE-1], s1_p};
    add_ovf   = sum_full[DATA_SIZE] ^ sum_full[DATA_SIZE-1];
    out_data  = sum_full[DATA_SIZE-1:0];
`ifdef EULER_SAT_EN
    if (add_ovf)
      out_data = sum_full[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                     : {1'b0, {(DATA_SIZE-1){1'b1}}};
`endif
    out_valid = s1_valid;
    out_row   = s1_row;
  end

  always_ff @(posedge clk) begin
    if (rst || clr)
      overflow <= 1'b0;
    else if ((in_valid && mul_ovf) || (s1_valid && add_ovf))
      overflow <= 1'b1;
  end

endmodule

// File: rtl/euler_state_update.sv
// Euler step x(n+1) = x(n) + h*f: shadow-buffered row updates, commit, step control.
// Build with EULER_SAT_EN for saturating arithmetic in the datapath.
module euler_state_update
  import euler_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter int unsigned MAX_DIM   = 6,
  parameter int unsigned MAX_ROWS  = 8,
  parameter int unsigned STEP_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] step_h,
  input  logic [MAX_DIM-1:0]   dim,
  input  logic [STEP_W-1:0]    num_steps,
  input  logic                 init_we,
  input  logic [MAX_DIM-1:0]   init_addr,
  input  logic [DATA_SIZE-1:0] init_data,
  input  logic                 acc_valid,
  input  logic [DATA_SIZE-1:0] acc_data,
  output logic                 acc_ready,
  output logic                 x_wr_en,
  output logic [MAX_DIM-1:0]   x_wr_addr,
  output logic [DATA_SIZE-1:0] x_wr_data,
  output logic                 step_done,
  output logic                 final_done,
  output logic                 overflow,
  output logic                 protocol_err
);

  localparam int unsigned AW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;

  state_t               state, state_nx;
  logic [DATA_SIZE-1:0] x_cur  [MAX_ROWS];
  logic [DATA_SIZE-1:0] shadow [MAX_ROWS];
  logic [DATA_SIZE-1:0] h_q;
  logic [MAX_DIM-1:0]   dim_q, dim_eff, last_row;
  logic [STEP_W-1:0]    num_q, num_eff;
  logic [MAX_DIM-1:0]   row_cnt, wr_cnt;
  logic [STEP_W-1:0]    step_cnt;
  logic                 drain_cnt;
  logic                 accept, last_step;
  logic [AW-1:0]        s1_row, mac_row;
  logic                 mac_valid;
  logic [DATA_SIZE-1:0] mac_data;

  always_comb begin
    dim_eff = dim;
    if (dim == '0)                             dim_eff = MAX_DIM'(1);
    else if (dim > MAX_DIM'(MAX_ROWS))         dim_eff = MAX_DIM'(MAX_ROWS);
    num_eff   = (num_steps == '0) ? STEP_W'(1) : num_steps;
    last_row  = dim_q - MAX_DIM'(1);
    last_step = (step_cnt + STEP_W'(1)) == num_q;
    acc_ready = (state == RUN);
    accept    = acc_valid && acc_ready && !start;
    x_wr_en   = (state == COMMIT);
    x_wr_addr = x_wr_en ? wr_cnt : '0;
    x_wr_data = x_wr_en ? shadow[wr_cnt[AW-1:0]] : '0;
    step_done = (state == STEP_END);
  end

  always_comb begin
    state_nx = state;
    if (start) state_nx = RUN;
    else begin
      case (state)
        IDLE:     state_nx = IDLE;
        RUN:      if (accept && row_cnt == last_row) state_nx = DRAIN;
        DRAIN:    if (drain_cnt) state_nx = COMMIT;
        COMMIT:   if (wr_cnt == last_row) state_nx = STEP_END;
        STEP_END: state_nx = last_step ? IDLE : RUN;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      row_cnt      <= '0;
      wr_cnt       <= '0;
      step_cnt     <= '0;
      drain_cnt    <= 1'b0;
      final_done   <= 1'b0;
      protocol_err <= 1'b0;
      h_q          <= '0;
      dim_q        <= MAX_DIM'(1);
      num_q        <= STEP_W'(1);
    end else begin
      state <= state_nx;
      if (start) begin
        h_q          <= step_h;
        dim_q        <= dim_eff;
        num_q        <= num_eff;
        row_cnt      <= '0;
        wr_cnt       <= '0;
        step_cnt     <= '0;
        drain_cnt    <= 1'b0;
        final_done   <= 1'b0;
        protocol_err <= 1'b0;
      end else begin
        if (acc_valid && !acc_ready) protocol_err <= 1'b1;
        case (state)
          RUN: begin
            drain_cnt <= 1'b0;
            if (accept) row_cnt <= row_cnt + MAX_DIM'(1);
          end
          DRAIN:  drain_cnt <= 1'b1;
          COMMIT: wr_cnt <= wr_cnt + MAX_DIM'(1);
          STEP_END: begin
            step_cnt <= step_cnt + STEP_W'(1);
            row_cnt  <= '0;
            wr_cnt   <= '0;
            if (last_step) final_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Buffers carry no reset; a reset mid-commit simply stops further x_cur updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && init_we && init_addr < MAX_DIM'(MAX_ROWS))
        x_cur[init_addr[AW-1:0]] <= init_data;
      if (state == COMMIT)
        x_cur[wr_cnt[AW-1:0]] <= shadow[wr_cnt[AW-1:0]];
    end
    if (mac_valid) shadow[mac_row] <= mac_data;
  end

  euler_fx_mac_update #(
    .DATA_SIZE(DATA_SIZE),
    .FRAC_BITS(FRAC_BITS),
    .ROW_W    (AW)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .in_valid (accept),
    .in_data  (acc_data),
    .in_row   (row_cnt[AW-1:0]),
    .step_h   (h_q),
    .s1_row   (s1_row),
    .x_row    (x_cur[s1_row]),
    .out_valid(mac_valid),
    .out_row  (mac_row),
    .out_data (mac_data),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_euler_state_update.sv
// Directed + randomized bench for euler_state_update with an arithmetic reference model.
module tb_euler_state_update;

  logic        clk = 1'b0;
  logic        rst, start, init_we, acc_valid;
  logic [15:0] step_h, init_data, acc_data, x_wr_data, num_steps;
  logic [5:0]  dim, init_addr, x_wr_addr;
  logic        acc_ready, x_wr_en, step_done, final_done, overflow, protocol_err;

  int n_checks = 0;
  int n_fail   = 0;
  int xm[8];
  int accs[8];
  int cur_h, cur_d, cur_n, step_i;
  bit ov_m, pe_m;

  always #5 clk = ~clk;

  euler_state_update #(
    .DATA_SIZE(16), .FRAC_BITS(8), .MAX_DIM(6), .MAX_ROWS(8), .STEP_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .step_h(step_h), .dim(dim),
    .num_steps(num_steps), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .acc_valid(acc_valid), .acc_data(acc_data),
    .acc_ready(acc_ready), .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr),
    .x_wr_data(x_wr_data), .step_done(step_done), .final_done(final_done),
    .overflow(overflow), .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int to_s16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'(signed'(t));
  endfunction

  function automatic int fit16(input longint v, output bit o);
    o = (v > 32767) || (v < -32768);
`ifdef EULER_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
`else
    return int'(shortint'(v));
`endif
  endfunction

  // x + ((acc*h) >> 8), each result fitted to 16 bits
  function automatic int model_upd(input int x, input int acc, input int h, inout bit ov);
    longint prod;
    int     p, s;
    bit     o1, o2;
    prod = (longint'(acc) * longint'(h)) >>> 8;
    p    = fit16(prod, o1);
    s    = fit16(longint'(x) + longint'(p), o2);
    ov   = ov | o1 | o2;
    return s;
  endfunction

  task automatic init_x(input int i, input int v);
    init_addr = 6'(i);
    init_data = 16'(v);
    init_we   = 1'b1;
    tick();
    init_we   = 1'b0;
    xm[i]     = to_s16(v);
  endtask

  task automatic start_run(input int h, input int d, input int n);
    step_h    = 16'(h);
    dim       = 6'(d);
    num_steps = 16'(n);
    start     = 1'b1;
    tick();
    start  = 1'b0;
    ov_m   = 1'b0;
    pe_m   = 1'b0;
    cur_h  = to_s16(h);
    cur_d  = (d == 0) ? 1 : (d > 8) ? 8 : d;
    cur_n  = (n == 0) ? 1 : n;
    step_i = 0;
    check("ready_after_start", acc_ready, 1);
  endtask

  task automatic run_step(input bit gaps, input bit poke);
    int newx[8];
    int k;
    for (int i = 0; i < cur_d; i++) newx[i] = model_upd(xm[i], accs[i], cur_h, ov_m);
    for (int i = 0; i < cur_d; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        acc_valid = 1'b0;
        tick();
      end
      acc_valid = 1'b1;
      acc_data  = 16'(accs[i]);
      tick();
    end
    acc_valid = 1'b0;
    k = 1;
    while (!x_wr_en && k < 20) begin
      tick();
      k++;
    end
    check("commit_latency", k, 3);
    for (int i = 0; i < cur_d; i++) begin
      check("wr_en", x_wr_en, 1);
      check("wr_addr", x_wr_addr, i);
      check("wr_data", x_wr_data, 32'(newx[i] & 16'hFFFF));
      if (poke && i == 0) begin
        acc_valid = 1'b1;
        acc_data  = 16'hDEAD;
        pe_m      = 1'b1;
      end
      tick();
      acc_valid = 1'b0;
    end
    check("step_done_pulse", step_done, 1);
    check("wr_en_after_commit", x_wr_en, 0);
    for (int i = 0; i < cur_d; i++) xm[i] = newx[i];
    step_i++;
    tick();
    check("step_done_low", step_done, 0);
    check("final_done", final_done, (step_i == cur_n) ? 1 : 0);
    check("ready_next", acc_ready, (step_i != cur_n) ? 1 : 0);
    check("overflow", overflow, ov_m);
    check("protocol_err", protocol_err, pe_m);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; init_we = 1'b0; acc_valid = 1'b0;
    step_h = '0; dim = '0; num_steps = '0; init_addr = '0; init_data = '0; acc_data = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_acc_ready", acc_ready, 0);
    check("rst_wr_en", x_wr_en, 0);
    check("rst_wr_addr", x_wr_addr, 0);
    check("rst_wr_data", x_wr_data, 0);
    check("rst_step_done", step_done, 0);
    check("rst_final_done", final_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_protocol_err", protocol_err, 0);

    // single-step basic update
    init_x(0, 16'h0100);
    init_x(1, 16'h0200);
    start_run(16'h0080, 2, 1);
    accs[0] = 16'h0200;
    accs[1] = 16'h0100;
    run_step(1'b0, 1'b0);

    // three steps, dim = 1
    init_x(0, 16'h0100);
    start_run(16'h0100, 1, 3);
    accs[0] = 16'h0100;
    for (int s = 0; s < 3; s++) run_step(1'b0, 1'b0);

    // back-to-back rows, dim = 4
    for (int i = 0; i < 4; i++) init_x(i, $urandom_range(0, 16'h0FFF));
    start_run($urandom_range(0, 16'h01FF), 4, 1);
    for (int i = 0; i < 4; i++) accs[i] = to_s16($urandom_range(0, 16'hFFFF));
    run_step(1'b0, 1'b0);

    // add overflow
    init_x(0, 16'h7F00);
    start_run(16'h0100, 1, 1);
    accs[0] = 16'h0200;
    run_step(1'b0, 1'b0);

    // acc_valid during COMMIT
    start_run($urandom_range(0, 16'h00FF), 3, 1);
    for (int i = 0; i < 3; i++) accs[i] = to_s16($urandom_range(0, 16'h0FFF));
    run_step(1'b0, 1'b1);

    // acc_valid while IDLE is dropped and flagged
    acc_valid = 1'b1;
    acc_data  = 16'h1234;
    tick();
    acc_valid = 1'b0;
    check("idle_protocol_err", protocol_err, 1);

    // abort mid-RUN after one of three rows
    init_x(0, 16'h7F00);
    start_run(16'h0100, 3, 1);
    acc_valid = 1'b1;
    acc_data  = 16'h0200;
    tick();
    acc_valid = 1'b0;
    tick();
    tick();
    check("pre_abort_overflow", overflow, 1);
    start_run(16'h0100, 3, 1);
    check("abort_overflow", overflow, 0);
    check("abort_protocol_err", protocol_err, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_write", x_wr_en, 0);
      tick();
    end
    accs[0] = 16'h0010; accs[1] = 16'h0020; accs[2] = 16'h0030;
    init_x(0, 16'h0100);
    // the init above is ignored outside IDLE, so the model keeps 0x7F00
    xm[0] = to_s16(16'h7F00);
    run_step(1'b0, 1'b0);

    // reset in the middle of COMMIT
    start_run(16'h0100, 2, 1);
    for (int i = 0; i < 2; i++) begin
      acc_valid = 1'b1;
      acc_data  = 16'h0040;
      tick();
    end
    acc_valid = 1'b0;
    for (int k = 0; k < 10 && !x_wr_en; k++) tick();
    check("pre_rst_commit", x_wr_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_commit_wr_en", x_wr_en, 0);
    check("rst_commit_ready", acc_ready, 0);
    check("rst_commit_final", final_done, 0);
    for (int i = 0; i < 8; i++) init_x(i, $urandom_range(0, 16'hFFFF));

    // dim above MAX_ROWS clamps, num_steps = 0 acts as 1
    start_run($urandom_range(0, 16'h03FF), 12, 0);
    for (int i = 0; i < 8; i++) accs[i] = to_s16($urandom_range(0, 16'hFFFF));
    run_step(1'b1, 1'b0);

    // randomized multi-step runs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) init_x(i, $urandom_range(0, 16'hFFFF));
      start_run($urandom_range(0, 16'hFFFF), $urandom_range(1, 8), $urandom_range(1, 3));
      for (int s = 0; s < cur_n; s++) begin
        for (int i = 0; i < 8; i++) accs[i] = to_s16($urandom_range(0, 16'hFFFF));
        run_step(1'b1, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
